tx_frame_serializer: RTL and testbench
======================================

Name: tx_frame_serializer

Overview:
- Output-side counterpart of the crossbar input path, one instance per output port.
- Buffers the switched header/payload words for one frame in a double-banked slot memory.
- Serializes the frame MSB-first onto the output line using the same bit-strobe timing and odd-parity header format that the receive side checks.
- The switch fabric writes bank `bank_sel`. The serializer reads and clears bank `~bank_sel`.

Parameters:
- PACKET_WIDTH, 8, bits per header/payload word; bit 0 of a header is the parity bit.
- SLOTS, 4, slots per frame; each slot is one header word followed by one payload word.
- SLOT_W, $clog2(SLOTS), width of the slot index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- bit_en  in  1  one-cycle serial bit strobe (clk10 domain rate).
- bank_sel  in  1  bank ownership; the fabric writes bank `bank_sel`, the serializer reads the other bank.
- wr_en  in  1  write strobe.
- wr_payload  in  1  0 = header array, 1 = payload array.
- wr_slot  in  SLOT_W  slot index.
- wr_data  in  PACKET_WIDTH  word to store.
- serial_out  out  1  serial line.
- tx_busy  out  1  frame in progress (ARMED or SHIFT).
- word_sync  out  1  high for the bit time carrying the MSB of each word.
- frame_done  out  1  one-cycle pulse at frame end.
- tx_overrun  out  1  one-cycle pulse when a frame is aborted by a bank swap.

Behaviour:
- Reset (rst=0, asynchronous):
  - serial_out, tx_busy, word_sync, frame_done and tx_overrun = 0.
  - FSM = IDLE, bit index = 0.
  - Both banks cleared to 0; the registered copy bank_q = 0.
- Writes (every clk with wr_en=1): store wr_data in bank `bank_sel` (value of the current cycle), array selected by wr_payload, slot wr_slot.
  - Writes never touch the read bank, so there is no read/write conflict.
  - A write in the same cycle as a bank_sel toggle lands in the new bank.
- Start: a swap is `bank_sel != bank_q`. bank_q <= bank_sel on every clk.
  - On a swap, rd_bank <= bank_q (the bank just released) and FSM -> ARMED.
- FSM:
  - IDLE: serial_out = 0. On swap -> ARMED.
  - ARMED: on bit_en, drive stream bit 0, idx <= 1 -> SHIFT.
  - SHIFT: on each bit_en, drive stream bit idx, idx++.
    - When the bit driven is the last one (idx = 2*SLOTS*PACKET_WIDTH-1) -> DRAIN.
  - DRAIN: on next bit_en, serial_out <= 0, frame_done pulses for 1 clk -> IDLE.
  - Between strobes all outputs hold their values; they update only on the clk edge where bit_en=1.
- Stream order, for slot 0..SLOTS-1: header word, then payload word, each MSB first.
  - Frame length = 2*SLOTS*PACKET_WIDTH strobes (64 at defaults).
- Parity: the transmitted header bit 0 is regenerated as `~^header[PACKET_WIDTH-1:1]`; the stored bit 0 is ignored.
  - Exception: a header stored as all-zero is sent as all-zero, which the receiver treats as an empty slot. Its payload is also sent as zeros.
- Clear-after-send: when the last payload bit of slot s is driven, clear header[s] and payload[s] of rd_bank to 0, so an unrefilled bank sends empty slots.
- word_sync = 1 while serial_out carries bit PACKET_WIDTH-1 of any word; 0 otherwise.
- Swap while in ARMED, SHIFT or DRAIN:
  - Abort the current frame; tx_overrun pulses for 1 clk.
  - Slots of the aborted bank not yet sent are left intact.
  - rd_bank <= bank_q, idx <= 0, FSM -> ARMED; serial_out <= 0 until the next bit_en.
- bit_en in the same cycle as a swap: the swap wins and no bit is driven that cycle.
- Reset mid-frame: immediate return to reset state; memory cleared.

Test Plan:
1. Single frame, parity rewrite:
   - Stimulus: bank_sel=0; write header slot0 = 0xA0, payload slot0 = 0x3C, slots 1-3 empty; toggle bank_sel=1; bit_en every 10 clk.
   - Required: serial_out = 1010_0001 then 0011_1100, then 48 zero bits.
   - Required: word_sync high on bit 0 and bit 8; frame_done one pulse after the 64th bit; tx_busy falls with it.
2. Parity passthrough:
   - Stimulus: header 0x52 written as 0x53.
   - Required: transmitted header = 0x52. A header written as 0xA1 is sent as 0xA1.
3. Double-bank ping-pong:
   - Stimulus: fill bank1 (headers 0x11, 0x21, 0x31, 0x41) during frame A; swap at frame end.
   - Required: frame B carries those words. A third swap with no new writes sends all-zero slots, proving clear-after-send.
4. Mid-frame swap:
   - Stimulus: toggle bank_sel after 20 bits.
   - Required: tx_overrun = 1 for 1 clk; serial_out = 0; the new frame starts at the next bit_en with bit 0 of the new bank's slot0 header.
5. Write during transmit:
   - Stimulus: wr_en into bank_sel while the other bank is shifting.
   - Required: transmitted bits are unaffected; written data appears in the next frame.
6. Async reset:
   - Stimulus: assert rst=0 mid-SHIFT, between clk edges.
   - Required: serial_out, tx_busy and word_sync = 0 immediately. After release, no output until a bank_sel swap; the swapped bank reads as all-zero.

Source files
------------

// File: rtl/tx_frame_serializer_if.sv
// rtl/tx_frame_serializer_if.sv - fabric-side write port and serial line of one output port
interface tx_frame_serializer_if #(
  parameter int PACKET_WIDTH = 8,
  parameter int SLOTS        = 4,
  parameter int SLOT_W       = $clog2(SLOTS)
);
  logic                    i_bit_en;
  logic                    i_bank_sel;
  logic                    i_wr_en;
  logic                    i_wr_payload;
  logic [SLOT_W-1:0]       i_wr_slot;
  logic [PACKET_WIDTH-1:0] i_wr_data;
  logic                    o_serial_out;
  logic                    o_tx_busy;
  logic                    o_word_sync;
  logic                    o_frame_done;
  logic                    o_tx_overrun;

  modport master (
    output i_bit_en, i_bank_sel, i_wr_en, i_wr_payload, i_wr_slot, i_wr_data,
    input  o_serial_out, o_tx_busy, o_word_sync, o_frame_done, o_tx_overrun
  );

  modport slave (
    input  i_bit_en, i_bank_sel, i_wr_en, i_wr_payload, i_wr_slot, i_wr_data,
    output o_serial_out, o_tx_busy, o_word_sync, o_frame_done, o_tx_overrun
  );
endinterface

// File: rtl/tx_frame_serializer.sv
// rtl/tx_frame_serializer.sv - double-banked frame buffer serialized MSB-first with odd header parity
module tx_frame_serializer #(
  parameter int PACKET_WIDTH = 8,
  parameter int SLOTS        = 4,
  parameter int SLOT_W       = $clog2(SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_frame_serializer_if.slave bus
);
  // Bit index decomposes as {slot, payload_flag, bit_in_word}; widths assume powers of two.
  localparam int BIT_W      = $clog2(PACKET_WIDTH);
  localparam int FRAME_BITS = 2 * SLOTS * PACKET_WIDTH;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DRAIN} state_t;

  state_t                  r_state, w_state_nx;
  logic [IDX_W-1:0]        r_idx, w_idx_nx;
  logic                    r_bank_q, r_rd_bank;
  logic                    r_serial, w_serial_nx;
  logic                    r_word_sync, w_word_sync_nx;
  logic                    r_frame_done, w_frame_done_nx;
  logic                    r_tx_overrun, w_tx_overrun_nx;
  logic [PACKET_WIDTH-1:0] r_hdr [2][SLOTS];
  logic [PACKET_WIDTH-1:0] r_pay [2][SLOTS];

  logic                    w_swap, w_clr, w_is_pay, w_bit;
  logic [SLOT_W-1:0]       w_slot;
  logic [BIT_W-1:0]        w_pos;
  logic [PACKET_WIDTH-1:0] w_hdr, w_word;

  assign w_swap   = bus.i_bank_sel != r_bank_q;
  assign w_slot   = r_idx[IDX_W-1 -: SLOT_W];
  assign w_is_pay = r_idx[BIT_W];
  assign w_pos    = ~r_idx[BIT_W-1:0];
  assign w_hdr    = r_hdr[r_rd_bank][w_slot];
  assign w_bit    = w_word[w_pos];

  // An all-zero header marks an empty slot: header and payload both go out as zeros.
  always_comb begin
    w_word = '0;
    if (w_hdr != '0) begin
      if (w_is_pay) w_word = r_pay[r_rd_bank][w_slot];
      else          w_word = {w_hdr[PACKET_WIDTH-1:1], ~^w_hdr[PACKET_WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_idx_nx        = r_idx;
    w_serial_nx     = r_serial;
    w_word_sync_nx  = r_word_sync;
    w_frame_done_nx = 1'b0;
    w_tx_overrun_nx = 1'b0;
    w_clr           = 1'b0;
    case (r_state)
      IDLE: begin
        w_serial_nx    = 1'b0;
        w_word_sync_nx = 1'b0;
        if (w_swap) begin
          w_state_nx = ARMED;
          w_idx_nx   = '0;
        end
      end
      ARMED, SHIFT, DRAIN: begin
        if (w_swap) begin
          w_state_nx      = ARMED;
          w_idx_nx        = '0;
          w_serial_nx     = 1'b0;
          w_word_sync_nx  = 1'b0;
          w_tx_overrun_nx = 1'b1;
        end else if (bus.i_bit_en && r_state == DRAIN) begin
          w_state_nx      = IDLE;
          w_idx_nx        = '0;
          w_serial_nx     = 1'b0;
          w_word_sync_nx  = 1'b0;
          w_frame_done_nx = 1'b1;
        end else if (bus.i_bit_en) begin
          w_serial_nx    = w_bit;
          w_word_sync_nx = (r_idx[BIT_W-1:0] == '0);
          w_idx_nx       = r_idx + 1'b1;
          w_state_nx     = (r_idx == LAST_IDX) ? DRAIN : SHIFT;
          w_clr          = &r_idx[BIT_W:0];
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_bank_q     <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_serial     <= 1'b0;
      r_word_sync  <= 1'b0;
      r_frame_done <= 1'b0;
      r_tx_overrun <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_bank_q     <= bus.i_bank_sel;
      r_serial     <= w_serial_nx;
      r_word_sync  <= w_word_sync_nx;
      r_frame_done <= w_frame_done_nx;
      r_tx_overrun <= w_tx_overrun_nx;
      if (w_swap) r_rd_bank <= r_bank_q;
    end
  end

  // Fabric writes and clear-after-send always target different banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SLOTS; s++) begin
          r_hdr[b][s] <= '0;
          r_pay[b][s] <= '0;
        end
      end
    end else begin
      if (bus.i_wr_en) begin
        if (bus.i_wr_payload) r_pay[bus.i_bank_sel][bus.i_wr_slot] <= bus.i_wr_data;
        else                  r_hdr[bus.i_bank_sel][bus.i_wr_slot] <= bus.i_wr_data;
      end
      if (w_clr) begin
        r_hdr[r_rd_bank][w_slot] <= '0;
        r_pay[r_rd_bank][w_slot] <= '0;
      end
    end
  end

  assign bus.o_serial_out = r_serial;
  assign bus.o_tx_busy    = (r_state != IDLE);
  assign bus.o_word_sync  = r_word_sync;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_tx_overrun = r_tx_overrun;
endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb/tb_tx_frame_serializer.sv - scoreboard bench for tx_frame_serializer
module tb_tx_frame_serializer;
  localparam int PW     = 8;
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_frame_serializer_if #(.PACKET_WIDTH(PW), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) tbif ();

  tx_frame_serializer #(.PACKET_WIDTH(PW), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tbif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  exp_q [$];
  logic [PW-1:0] m_hdr [2][SLOTS];
  logic [PW-1:0] m_pay [2][SLOTS];
  logic        m_rd;
  int          m_idx;
  logic [15:0] cap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < SLOTS; s++) begin
        m_hdr[b][s] = '0;
        m_pay[b][s] = '0;
      end
  endtask

  task automatic wr(input logic pay, input int slot, input logic [PW-1:0] d);
    tbif.i_wr_en      = 1'b1;
    tbif.i_wr_payload = pay;
    tbif.i_wr_slot    = SLOT_W'(slot);
    tbif.i_wr_data    = d;
    if (pay) m_pay[tbif.i_bank_sel][slot] = d;
    else     m_hdr[tbif.i_bank_sel][slot] = d;
    tick();
    tbif.i_wr_en = 1'b0;
  endtask

  // Toggle ownership and queue the frame the released bank should produce.
  task automatic swap();
    logic [PW-1:0] h, wd;
    m_rd  = tbif.i_bank_sel;
    m_idx = 0;
    tbif.i_bank_sel = ~tbif.i_bank_sel;
    for (int s = 0; s < SLOTS; s++)
      for (int w = 0; w < 2; w++) begin
        h = m_hdr[m_rd][s];
        if (h == '0)  wd = '0;
        else if (w == 1) wd = m_pay[m_rd][s];
        else wd = {h[PW-1:1], ~^h[PW-1:1]};
        for (int b = PW - 1; b >= 0; b--) exp_q.push_back({(b == PW - 1), wd[b]});
      end
  endtask

  task automatic strobe();
    repeat (9) tick();
    tbif.i_bit_en = 1'b1;
    tick();
    tbif.i_bit_en = 1'b0;
  endtask

  task automatic send_bits(input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      strobe();
      cap = {cap[14:0], tbif.o_serial_out};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: got ws/bit=%b, nothing expected", {tbif.o_word_sync, tbif.o_serial_out});
      end else begin
        e = exp_q.pop_front();
        if ({tbif.o_word_sync, tbif.o_serial_out} !== e) begin
          n_err++;
          $display("FAIL stream_bit[%0d]: ws/bit=%b expected %b", m_idx, {tbif.o_word_sync, tbif.o_serial_out}, e);
        end
      end
      m_idx++;
      if (m_idx % (2 * PW) == 0) begin
        m_hdr[m_rd][m_idx / (2 * PW) - 1] = '0;
        m_pay[m_rd][m_idx / (2 * PW) - 1] = '0;
      end
    end
  endtask

  task automatic finish_frame();
    n_vec++;
    if (tbif.o_tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_before_drain: got %b expected 1", tbif.o_tx_busy);
    end
    strobe();
    n_vec++;
    if ({tbif.o_serial_out, tbif.o_frame_done, tbif.o_tx_busy, tbif.o_word_sync} !== 4'b0100) begin
      n_err++;
      $display("FAIL drain serial/done/busy/ws: got %b expected 0100",
               {tbif.o_serial_out, tbif.o_frame_done, tbif.o_tx_busy, tbif.o_word_sync});
    end
    tick();
    n_vec++;
    if (tbif.o_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL frame_done_width: got %b expected 0", tbif.o_frame_done);
    end
  endtask

  task automatic check_cap(input string name, input logic [15:0] want);
    n_vec++;
    if (cap !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, cap, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_vec++;
    if ({tbif.o_serial_out, tbif.o_tx_busy, tbif.o_word_sync, tbif.o_frame_done, tbif.o_tx_overrun} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {tbif.o_serial_out, tbif.o_tx_busy, tbif.o_word_sync, tbif.o_frame_done, tbif.o_tx_overrun});
    end
    rst = 1'b1;
    tick();
    strobe();
    strobe();
    n_vec++;
    if ({tbif.o_serial_out, tbif.o_tx_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_output: got %b expected 00", {tbif.o_serial_out, tbif.o_tx_busy});
    end
  endtask

  task automatic test_single_frame();
    wr(1'b0, 0, 8'hA0);
    wr(1'b1, 0, 8'h3C);
    swap();
    send_bits(16);
    check_cap("single_slot0", 16'hA13C);
    send_bits(48);
    check_cap("single_tail_zero", 16'h0000);
    finish_frame();
  endtask

  task automatic test_parity();
    wr(1'b0, 0, 8'h53);
    wr(1'b1, 0, 8'h5A);
    wr(1'b0, 1, 8'hA1);
    wr(1'b1, 1, 8'h77);
    swap();
    send_bits(16);
    check_cap("parity_rewrite", 16'h525A);
    send_bits(16);
    check_cap("parity_pass", 16'hA177);
    send_bits(32);
    finish_frame();
  endtask

  task automatic test_back_to_back();
    wr(1'b0, 0, 8'hC3);
    wr(1'b1, 0, 8'h81);
    swap();
    send_bits(8);
    for (int s = 0; s < SLOTS; s++) begin
      wr(1'b0, s, 8'(8'h11 + 8'h10 * s));
      wr(1'b1, s, 8'(s + 1));
      send_bits(8);
    end
    send_bits(24);
    finish_frame();
    swap();
    send_bits(16);
    check_cap("pingpong_slot0", 16'h1001);
    send_bits(48);
    check_cap("pingpong_slot3", 16'h4004);
    finish_frame();
    swap();
    send_bits(64);
    finish_frame();
  endtask

  task automatic test_mid_swap();
    for (int s = 0; s < SLOTS; s++) begin
      wr(1'b0, s, 8'(8'h5A + 8'h11 * s));
      wr(1'b1, s, 8'(8'hF0 + s));
    end
    swap();
    wr(1'b0, 0, 8'hE6);
    wr(1'b1, 0, 8'h99);
    send_bits(20);
    exp_q.delete();
    swap();
    tick();
    n_vec++;
    if ({tbif.o_tx_overrun, tbif.o_serial_out, tbif.o_word_sync} !== 3'b100) begin
      n_err++;
      $display("FAIL abort_pulse ovr/serial/ws: got %b expected 100",
               {tbif.o_tx_overrun, tbif.o_serial_out, tbif.o_word_sync});
    end
    tick();
    n_vec++;
    if (tbif.o_tx_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_width: got %b expected 0", tbif.o_tx_overrun);
    end
    send_bits(16);
    check_cap("abort_new_frame", 16'hE699);
    send_bits(48);
    finish_frame();
    swap();
    send_bits(16);
    check_cap("aborted_slot0_cleared", 16'h0000);
    send_bits(16);
    check_cap("aborted_slot1_intact", 16'h6BF1);
    send_bits(32);
    finish_frame();
  endtask

  task automatic test_async_reset();
    wr(1'b0, 0, 8'hFF);
    wr(1'b1, 0, 8'hFF);
    swap();
    wr(1'b0, 1, 8'h33);
    wr(1'b1, 1, 8'h44);
    send_bits(3);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({tbif.o_serial_out, tbif.o_tx_busy, tbif.o_word_sync} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %b expected 000",
               {tbif.o_serial_out, tbif.o_tx_busy, tbif.o_word_sync});
    end
    clear_model();
    exp_q.delete();
    tbif.i_bank_sel = 1'b0;
    tick();
    rst = 1'b1;
    strobe();
    strobe();
    n_vec++;
    if ({tbif.o_serial_out, tbif.o_tx_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected 00", {tbif.o_serial_out, tbif.o_tx_busy});
    end
    swap();
    send_bits(64);
    finish_frame();
    swap();
    send_bits(64);
    finish_frame();
  endtask

  initial begin
    tbif.i_bit_en     = 1'b0;
    tbif.i_bank_sel   = 1'b0;
    tbif.i_wr_en      = 1'b0;
    tbif.i_wr_payload = 1'b0;
    tbif.i_wr_slot    = '0;
    tbif.i_wr_data    = '0;
    cap   = '0;
    m_rd  = 1'b0;
    m_idx = 0;
    clear_model();
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_mid_swap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
